// File: rtl/m_prog_loader_if.sv
// Byte-stream and memory-write bundle for the program loader.
//   master : loader side (consumes bytes, drives memory write and status)
//   slave  : environment side (byte source, memory and core-reset sink)
// Signals:
//   w_rx_valid / w_rx_data / r_rx_ready : byte stream with valid/ready handshake
//   r_addr / r_wdata / r_we             : word-addressed memory write port
//   r_proc_rst                          : hold-reset to the processor core
//   r_done / r_err / r_words            : load status
interface m_prog_loader_if #(
    parameter int ADDR_W = 11
);
    logic              w_rx_valid;
    logic [7:0]        w_rx_data;
    logic              r_rx_ready;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic              r_proc_rst;
    logic              r_done;
    logic              r_err;
    logic [11:0]       r_words;

    modport master (
        input  w_rx_valid, w_rx_data,
        output r_rx_ready, r_addr, r_wdata, r_we, r_proc_rst, r_done, r_err, r_words
    );

    modport slave (
        output w_rx_valid, w_rx_data,
        input  r_rx_ready, r_addr, r_wdata, r_we, r_proc_rst, r_done, r_err, r_words
    );
endinterface

// File: rtl/m_prog_loader.sv
// Boot-time program loader. Assembles big-endian 32-bit words from a byte
// stream, writes the data words to consecutive memory word addresses, checks a
// trailing checksum (sum of data words mod 2^32) and releases the core reset
// only once the whole image has been loaded and verified.
// Image format: header word N, N data words, checksum word.
// Ports:
//   w_clk  : single clock, rising edge
//   w_rst  : synchronous active-high reset
//   bus    : m_prog_loader_if.master (byte stream in, memory write + status out)
module m_prog_loader #(
    parameter int ADDR_W    = 11,
    parameter int MAX_WORDS = 2048
) (
    input  logic              w_clk,
    input  logic              w_rst,
    m_prog_loader_if.master   bus
);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_SUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic [1:0]        byte_idx;
    logic [23:0]       shift;      // first three bytes of the word in flight
    logic [11:0]       n_words;
    logic [31:0]       acc;

    logic              rx_ready;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              we;
    logic              proc_rst;
    logic              done;
    logic              err;
    logic [11:0]       words;

    logic              accept;
    logic              word_done;
    logic [31:0]       word;

    assign accept    = bus.w_rx_valid && rx_ready;
    assign word_done = accept && (byte_idx == 2'd3);
    assign word      = {shift, bus.w_rx_data};

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state    <= S_HDR;
            byte_idx <= 2'd0;
            shift    <= 24'd0;
            n_words  <= 12'd0;
            acc      <= 32'd0;
            rx_ready <= 1'b1;
            addr     <= '0;
            wdata    <= 32'd0;
            we       <= 1'b0;
            proc_rst <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            words    <= 12'd0;
        end else begin
            we <= 1'b0;
            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                shift    <= {shift[15:0], bus.w_rx_data};
            end
            if (word_done) begin
                case (state)
                    S_HDR: begin
                        if (word > 32'(MAX_WORDS)) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            rx_ready <= 1'b0;
                        end else if (word == 32'd0) begin
                            state <= S_SUM;
                        end else begin
                            // word <= MAX_WORDS here, so the low 12 bits hold N exactly
                            n_words <= word[11:0];
                            state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        // write is presented the cycle after the 4th byte
                        we    <= 1'b1;
                        wdata <= word;
                        addr  <= words[ADDR_W-1:0];
                        words <= words + 12'd1;
                        acc   <= acc + word;
                        if (words + 12'd1 == n_words) begin
                            state <= S_SUM;
                        end
                    end
                    S_SUM: begin
                        rx_ready <= 1'b0;
                        if (word == acc) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            proc_rst <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                    default: ;  // S_DONE / S_ERR: rx_ready is low, no bytes arrive
                endcase
            end
        end
    end

    assign bus.r_rx_ready = rx_ready;
    assign bus.r_addr     = addr;
    assign bus.r_wdata    = wdata;
    assign bus.r_we       = we;
    assign bus.r_proc_rst = proc_rst;
    assign bus.r_done     = done;
    assign bus.r_err      = err;
    assign bus.r_words    = words;

endmodule

// File: tb/tb_m_prog_loader.sv
// Directed testbench for m_prog_loader with a write scoreboard.
module tb_m_prog_loader;

    logic w_clk;
    logic w_rst;

    m_prog_loader_if #(.ADDR_W(11)) bus ();

    m_prog_loader #(.ADDR_W(11), .MAX_WORDS(2048)) dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .bus   (bus.master)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    typedef struct {
        logic [10:0] addr;
        logic [31:0] data;
        time         t;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every r_we pulse must match the oldest expected write,
    // including the cycle in which it appears.
    always @(negedge w_clk) begin
        if (bus.r_we === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_we observed addr=0x%0h data=0x%08h expected no write",
                       bus.r_addr, bus.r_wdata);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                assert (bus.r_addr === e.addr) else begin
                    failures++;
                    $error("FAIL we_addr observed=0x%0h expected=0x%0h", bus.r_addr, e.addr);
                end
                checks++;
                assert (bus.r_wdata === e.data) else begin
                    failures++;
                    $error("FAIL we_data observed=0x%08h expected=0x%08h", bus.r_wdata, e.data);
                end
                checks++;
                assert ($time === e.t) else begin
                    failures++;
                    $error("FAIL we_latency observed_t=%0t expected_t=%0t", $time, e.t);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, output time t);
        repeat (gap) @(posedge w_clk);
        #1;
        bus.w_rx_valid = 1'b1;
        bus.w_rx_data  = b;
        @(posedge w_clk);
        t = $time;
        #1;
        bus.w_rx_valid = 1'b0;
    endtask

    // is_data: push the expected write (visible at the negedge after the 4th byte)
    task automatic send_word(input logic [31:0] w, input bit is_data,
                             input logic [10:0] addr, input int maxgap);
        time t;
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, t);
        end
        if (is_data) begin
            exp_t e;
            e.addr = addr;
            e.data = w;
            e.t    = t + 5;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        #1;
        w_rst = 1'b1;
        @(posedge w_clk);
        #1;
        w_rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"},    64'(bus.r_rx_ready), 64'd1);
        chk({tag, "_addr"},     64'(bus.r_addr),     64'd0);
        chk({tag, "_wdata"},    64'(bus.r_wdata),    64'd0);
        chk({tag, "_we"},       64'(bus.r_we),       64'd0);
        chk({tag, "_proc_rst"}, 64'(bus.r_proc_rst), 64'd1);
        chk({tag, "_done"},     64'(bus.r_done),     64'd0);
        chk({tag, "_err"},      64'(bus.r_err),      64'd0);
        chk({tag, "_words"},    64'(bus.r_words),    64'd0);
    endtask

    task automatic check_final(input string tag, input logic done, input logic err,
                               input logic [11:0] words);
        repeat (3) @(posedge w_clk);
        #1;
        chk({tag, "_done"},     64'(bus.r_done),     64'(done));
        chk({tag, "_err"},      64'(bus.r_err),      64'(err));
        chk({tag, "_proc_rst"}, 64'(bus.r_proc_rst), 64'(!done));
        chk({tag, "_ready"},    64'(bus.r_rx_ready), 64'd0);
        chk({tag, "_words"},    64'(bus.r_words),    64'(words));
        chk({tag, "_q_empty"},  64'(exp_q.size()),   64'd0);
    endtask

    task automatic send_image(input logic [31:0] sum, input int maxgap);
        send_word(32'd2,          1'b0, 11'd0, maxgap);
        send_word(32'h1234_5678,  1'b1, 11'd0, maxgap);
        send_word(32'h0000_0020,  1'b1, 11'd1, maxgap);
        send_word(sum,            1'b0, 11'd0, maxgap);
    endtask

    initial begin
        time t;
        w_rst          = 1'b1;
        bus.w_rx_valid = 1'b0;
        bus.w_rx_data  = 8'h00;
        @(posedge w_clk);
        do_reset();
        check_reset_vals("rst0");

        // good two-word image, back-to-back bytes
        send_image(32'h1234_5698, 0);
        check_final("good", 1'b1, 1'b0, 12'd2);
        chk("good_addr_hold",  64'(bus.r_addr),  64'd1);
        chk("good_wdata_hold", 64'(bus.r_wdata), 64'h20);
        // bytes after completion are ignored
        #1; bus.w_rx_valid = 1'b1; bus.w_rx_data = 8'hAA;
        repeat (5) @(posedge w_clk);
        #1; bus.w_rx_valid = 1'b0;
        chk("ignored_words", 64'(bus.r_words), 64'd2);
        chk("ignored_done",  64'(bus.r_done),  64'd1);

        // bad checksum
        do_reset();
        check_reset_vals("rst1");
        send_image(32'h1234_5699, 0);
        check_final("badsum", 1'b0, 1'b1, 12'd2);

        // oversize header N = 2049
        do_reset();
        send_word(32'h0000_0801, 1'b0, 11'd0, 0);
        chk("oversize_err_now",   64'(bus.r_err),      64'd1);
        chk("oversize_ready_now", 64'(bus.r_rx_ready), 64'd0);
        check_final("oversize", 1'b0, 1'b1, 12'd0);

        // empty image
        do_reset();
        send_word(32'd0, 1'b0, 11'd0, 0);
        send_word(32'd0, 1'b0, 11'd0, 0);
        check_final("empty", 1'b1, 1'b0, 12'd0);

        // random valid gaps
        do_reset();
        send_image(32'h1234_5698, 3);
        check_final("gaps", 1'b1, 1'b0, 12'd2);

        // reset after two bytes of the first data word, then a full reload
        do_reset();
        send_word(32'd2, 1'b0, 11'd0, 0);
        send_byte(8'h12, 0, t);
        send_byte(8'h34, 0, t);
        do_reset();
        check_reset_vals("midrst");
        send_image(32'h1234_5698, 0);
        check_final("reload", 1'b1, 1'b0, 12'd2);

        // reset coincides with the 4th byte of a data word: no write, byte dropped
        do_reset();
        send_word(32'd2, 1'b0, 11'd0, 0);
        send_byte(8'h12, 0, t);
        send_byte(8'h34, 0, t);
        send_byte(8'h56, 0, t);
        #1;
        w_rst          = 1'b1;
        bus.w_rx_valid = 1'b1;
        bus.w_rx_data  = 8'h78;
        @(posedge w_clk);
        #1;
        w_rst          = 1'b0;
        bus.w_rx_valid = 1'b0;
        check_reset_vals("colrst");
        repeat (3) @(posedge w_clk);
        #1;
        chk("colrst_words_after", 64'(bus.r_words), 64'd0);
        chk("colrst_q_empty",     64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
